// File: rtl/nvme_arb_pkg.sv
// Shared types and tag helpers for the NVMe-to-CAFU request arbiter.
// Tag layout is {is_wr, ch}; source index layout is {ch, is_wr}.
package nvme_arb_pkg;

  localparam int ADDR_W    = 64;
  localparam int DATA_W    = 512;
  localparam int STRB_W    = 64;
  localparam int MAX_TAG_W = 8;

  typedef struct packed {
    logic                 is_wr;
    logic [MAX_TAG_W-1:0] tag;
    logic [ADDR_W-1:0]    addr;
    logic [DATA_W-1:0]    wdata;
    logic [STRB_W-1:0]    wstrb;
  } req_t;

  function automatic int calc_tag_w(input int ch);
    return $clog2(ch) + 1;
  endfunction

  // Source index -> tag.
  function automatic int src_encode_tag(input int src, input int ch_w);
    return ((src % 2) << ch_w) | (src / 2);
  endfunction

  // Tag -> source index.
  function automatic int tag_decode_src(input int tag, input int ch_w);
    return ((tag & ((1 << ch_w) - 1)) << 1) | ((tag >> ch_w) & 1);
  endfunction

endpackage

// File: rtl/rr_arb.sv
// N-way round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_arb #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      int sum;
      logic [PTR_W-1:0] j;
      sum = int'(ptr) + i;
      if (sum >= N) sum = sum - N;
      j = PTR_W'(sum);
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/nvme_cafu_arb.sv
// Shares one CAFU request/response port between CH NVMe channels (read + write source each).
// Requires CH >= 2 so the tag carries at least one channel bit.
module nvme_cafu_arb
  import nvme_arb_pkg::*;
#(
  parameter int CH              = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TAG_W           = calc_tag_w(CH)
) (
  input  logic                                 afu_clk,
  input  logic                                 afu_rstn,
  input  logic                                 i_end_proc,
  input  logic                                 rd_valid        [CH-1:0],
  output logic                                 rd_ready        [CH-1:0],
  input  logic [63:0]                          rd_araddr       [CH-1:0],
  output logic                                 rd_return_valid [CH-1:0],
  input  logic                                 rd_return_ready [CH-1:0],
  output logic [511:0]                         rd_rdata        [CH-1:0],
  input  logic                                 wr_valid        [CH-1:0],
  output logic                                 wr_ready        [CH-1:0],
  input  logic [63:0]                          wr_awaddr       [CH-1:0],
  input  logic [511:0]                         wr_wdata        [CH-1:0],
  input  logic [63:0]                          wr_wstrb        [CH-1:0],
  output logic                                 wr_return_valid [CH-1:0],
  input  logic                                 wr_return_ready [CH-1:0],
  output logic                                 req_valid,
  input  logic                                 req_ready,
  output logic                                 req_is_wr,
  output logic [TAG_W-1:0]                     req_tag,
  output logic [63:0]                          req_addr,
  output logic [511:0]                         req_wdata,
  output logic [63:0]                          req_wstrb,
  input  logic                                 resp_valid,
  output logic                                 resp_ready,
  input  logic [TAG_W-1:0]                     resp_tag,
  input  logic [511:0]                         resp_rdata,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] o_outstanding,
  output logic                                 o_err_unexp_resp
);

  localparam int NS    = 2 * CH;
  localparam int PTR_W = $clog2(NS);
  localparam int CH_W  = PTR_W - 1;
  localparam int OC_W  = $clog2(MAX_OUTSTANDING + 1);

  req_t             out_q, grant_req;
  logic             out_valid_q;
  logic [NS-1:0]    pending_q, pending_d;
  logic [OC_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0] rr_ptr_q, next_ptr;
  logic             err_q;
  logic             active_q;

  logic [NS-1:0]    src_valid, req_vec, arb_gnt, gnt;
  logic [PTR_W-1:0] arb_idx;
  logic [CH_W-1:0]  grant_ch;
  logic             arb_any, can_grant, grant;

  logic [PTR_W-1:0] resp_src;
  logic [CH_W-1:0]  resp_ch;
  logic             resp_hit, resp_hs, resp_unexp;

  // ---------------- request side ----------------
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      src_valid[2*c]   = rd_valid[c];
      src_valid[2*c+1] = wr_valid[c];
    end
  end

  assign req_vec = src_valid & ~pending_q;

  rr_arb #(.N(NS), .PTR_W(PTR_W)) u_rr_arb (
    .req (req_vec),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // NOTE: active_q holds every ready low while afu_rstn is asserted, so the purely
  // combinational handshakes also show their reset values during reset.
  assign can_grant = active_q && !i_end_proc && (!out_valid_q || req_ready) &&
                     (count_q < OC_W'(MAX_OUTSTANDING));
  assign grant     = can_grant && arb_any;
  assign gnt       = grant ? arb_gnt : '0;
  assign next_ptr  = (int'(arb_idx) == NS - 1) ? '0 : arb_idx + PTR_W'(1);
  assign grant_ch  = arb_idx[PTR_W-1:1];

  always_comb begin
    for (int c = 0; c < CH; c++) begin
      rd_ready[c] = gnt[2*c];
      wr_ready[c] = gnt[2*c+1];
    end
  end

  always_comb begin
    grant_req       = '0;
    grant_req.is_wr = arb_idx[0];
    grant_req.tag   = MAX_TAG_W'(src_encode_tag(int'(arb_idx), CH_W));
    if (arb_idx[0]) begin
      grant_req.addr  = wr_awaddr[grant_ch];
      grant_req.wdata = wr_wdata[grant_ch];
      grant_req.wstrb = wr_wstrb[grant_ch];
    end else begin
      grant_req.addr  = rd_araddr[grant_ch];
    end
  end

  assign req_valid = out_valid_q;
  assign req_is_wr = out_q.is_wr;
  assign req_tag   = TAG_W'(out_q.tag);
  assign req_addr  = out_q.addr;
  assign req_wdata = out_q.wdata;
  assign req_wstrb = out_q.wstrb;

  // ---------------- response side ----------------
  assign resp_src = PTR_W'(tag_decode_src(int'(resp_tag), CH_W));
  assign resp_ch  = resp_src[PTR_W-1:1];
  // A flush cycle treats every response as stale, even one whose pending bit is still set.
  assign resp_hit   = active_q && !i_end_proc && (int'(resp_src) < NS) && pending_q[resp_src];
  assign resp_hs    = resp_hit && resp_valid && resp_ready;
  assign resp_unexp = active_q && resp_valid && !resp_hit;

  always_comb begin
    resp_ready = active_q;
    for (int c = 0; c < CH; c++) begin
      rd_return_valid[c] = 1'b0;
      wr_return_valid[c] = 1'b0;
      rd_rdata[c]        = '0;
      if (resp_hit && resp_ch == CH_W'(c)) begin
        if (resp_src[0]) begin
          wr_return_valid[c] = resp_valid;
          resp_ready         = wr_return_ready[c];
        end else begin
          rd_return_valid[c] = resp_valid;
          rd_rdata[c]        = resp_rdata;
          resp_ready         = rd_return_ready[c];
        end
      end
    end
  end

  // ---------------- state update ----------------
  always_comb begin
    pending_d = pending_q;
    if (resp_hs) pending_d[resp_src] = 1'b0;
    pending_d = pending_d | gnt;
  end

  always_comb begin
    count_d = count_q;
    if (grant && !resp_hs)      count_d = count_q + OC_W'(1);
    else if (!grant && resp_hs) count_d = count_q - OC_W'(1);
  end

  // NOTE: all state here uses non-blocking assignment so every register samples
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge afu_clk or negedge afu_rstn) begin
    if (!afu_rstn) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      pending_q   <= '0;
      count_q     <= '0;
      rr_ptr_q    <= '0;
      err_q       <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      active_q <= 1'b1;
      if (resp_unexp) err_q <= 1'b1;
      if (i_end_proc) begin
        out_q       <= '0;
        out_valid_q <= 1'b0;
        pending_q   <= '0;
        count_q     <= '0;
        rr_ptr_q    <= '0;
      end else begin
        pending_q <= pending_d;
        count_q   <= count_d;
        if (grant) begin
          out_q       <= grant_req;
          out_valid_q <= 1'b1;
          rr_ptr_q    <= next_ptr;
        end else if (out_valid_q && req_ready) begin
          out_q       <= '0;
          out_valid_q <= 1'b0;
        end
      end
    end
  end

  assign o_outstanding    = count_q;
  assign o_err_unexp_resp = err_q;

endmodule
